// File: rtl/pixel_riscv_soc_pkg.sv
// Shared SoC definitions: timer register map, field positions and reset values.
package pixel_riscv_soc_pkg;

  localparam logic [11:0] TMR_CR_OFF  = 12'h000;
  localparam logic [11:0] TMR_SR_OFF  = 12'h004;
  localparam logic [11:0] TMR_CNT_OFF = 12'h008;
  localparam logic [11:0] TMR_CMP_OFF = 12'h00C;
  localparam logic [11:0] TMR_PSC_OFF = 12'h010;

  localparam int unsigned TMR_CR_EN_BIT       = 0;
  localparam int unsigned TMR_CR_IRQ_EN_BIT   = 1;
  localparam int unsigned TMR_CR_AUTO_CLR_BIT = 2;
  localparam int unsigned TMR_SR_MATCH_BIT    = 0;

  localparam logic [31:0] TMR_CMP_RST = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    SEL_CR,
    SEL_SR,
    SEL_CNT,
    SEL_CMP,
    SEL_PSC,
    SEL_NONE
  } tmr_sel_e;

  // Replace only the bytes of old_val whose byte enable is set.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/soc_timer_prescaler.sv
// Prescaler: one-cycle tick every (psc+1) enabled cycles; counter cleared while disabled.
module soc_timer_prescaler
  import pixel_riscv_soc_pkg::*;
#(
  parameter int PSC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [PSC_WIDTH-1:0] psc,
  output logic                 tick
);

  logic [PSC_WIDTH-1:0] cnt;

  assign tick = en && (cnt == psc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/soc_timer.sv
// SoC timer: bus slave with CR/SR/CNT/CMP/PSC registers, compare match and level irq.
module soc_timer
  import pixel_riscv_soc_pkg::*;
#(
  parameter int PSC_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  output logic        gnt,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic        rvalid,
  output logic        err,
  output logic [31:0] rdata,
  output logic        irq
);

  logic                 cr_en, cr_irq_en, cr_auto_clr;
  logic                 sr_match;
  logic [31:0]          cnt, cmp;
  logic [PSC_WIDTH-1:0] psc;
  logic                 tick;

  tmr_sel_e             sel;
  logic                 mapped, wr;
  logic [31:0]          cr_word, sr_word, psc_word, rd_val;
  logic [31:0]          cr_merged, psc_merged;
  logic                 match_hit, sr_clr;
  logic                 unused_bits;

  assign gnt = req;

  always_comb begin
    sel = SEL_NONE;
    case (addr[11:2])
      TMR_CR_OFF[11:2]:  sel = SEL_CR;
      TMR_SR_OFF[11:2]:  sel = SEL_SR;
      TMR_CNT_OFF[11:2]: sel = SEL_CNT;
      TMR_CMP_OFF[11:2]: sel = SEL_CMP;
      TMR_PSC_OFF[11:2]: sel = SEL_PSC;
      default:           sel = SEL_NONE;
    endcase
  end

  assign mapped = (sel != SEL_NONE);
  assign wr     = req && we && mapped;

  always_comb begin
    cr_word                      = '0;
    cr_word[TMR_CR_EN_BIT]       = cr_en;
    cr_word[TMR_CR_IRQ_EN_BIT]   = cr_irq_en;
    cr_word[TMR_CR_AUTO_CLR_BIT] = cr_auto_clr;
    sr_word                      = '0;
    sr_word[TMR_SR_MATCH_BIT]    = sr_match;
    psc_word                     = '0;
    psc_word[PSC_WIDTH-1:0]      = psc;
  end

  always_comb begin
    rd_val = '0;
    case (sel)
      SEL_CR:  rd_val = cr_word;
      SEL_SR:  rd_val = sr_word;
      SEL_CNT: rd_val = cnt;
      SEL_CMP: rd_val = cmp;
      SEL_PSC: rd_val = psc_word;
      default: rd_val = '0;
    endcase
  end

  assign cr_merged  = be_merge(cr_word, wdata, be);
  assign psc_merged = be_merge(psc_word, wdata, be);
  assign unused_bits = ^{addr[31:12], addr[1:0], cr_merged, psc_merged};

  assign match_hit = tick && (cnt == cmp);
  assign sr_clr    = wr && (sel == SEL_SR) && be[TMR_SR_MATCH_BIT / 8]
                     && wdata[TMR_SR_MATCH_BIT];

  soc_timer_prescaler #(
    .PSC_WIDTH(PSC_WIDTH)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (cr_en),
    .psc  (psc),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cr_en       <= 1'b0;
      cr_irq_en   <= 1'b0;
      cr_auto_clr <= 1'b0;
      cmp         <= TMR_CMP_RST;
      psc         <= '0;
    end else if (wr) begin
      case (sel)
        SEL_CR: begin
          cr_en       <= cr_merged[TMR_CR_EN_BIT];
          cr_irq_en   <= cr_merged[TMR_CR_IRQ_EN_BIT];
          cr_auto_clr <= cr_merged[TMR_CR_AUTO_CLR_BIT];
        end
        SEL_CMP: cmp <= be_merge(cmp, wdata, be);
        SEL_PSC: psc <= psc_merged[PSC_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Match-set wins over W1C; a bus write to CNT wins over tick update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_match <= 1'b0;
      cnt      <= '0;
    end else begin
      if (match_hit)   sr_match <= 1'b1;
      else if (sr_clr) sr_match <= 1'b0;

      if (wr && (sel == SEL_CNT)) cnt <= be_merge(cnt, wdata, be);
      else if (tick)              cnt <= (match_hit && cr_auto_clr) ? '0 : cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
      irq    <= 1'b0;
    end else begin
      rvalid <= req;
      err    <= req && !mapped;
      rdata  <= (req && !we && mapped) ? rd_val : '0;
      irq    <= sr_match && cr_irq_en;
    end
  end

endmodule

// File: tb/tb_soc_timer.sv
// Directed self-checking bench for soc_timer; bus driven and sampled on the falling edge.
module tb_soc_timer;

  localparam logic [31:0] BASE = 32'h0100_3000;
  localparam logic [11:0] CR  = 12'h000;
  localparam logic [11:0] SR  = 12'h004;
  localparam logic [11:0] CNT = 12'h008;
  localparam logic [11:0] CMP = 12'h00C;
  localparam logic [11:0] PSC = 12'h010;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic        err;
  logic [31:0] rdata;
  logic        irq;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  soc_timer #(
    .PSC_WIDTH(16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .gnt    (gnt),
    .addr   (addr),
    .we     (we),
    .be     (be),
    .wdata  (wdata),
    .rvalid (rvalid),
    .err    (err),
    .rdata  (rdata),
    .irq    (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One bus transaction; the next call may start immediately, giving back-to-back requests.
  task automatic bus(input logic w, input logic [11:0] off, input logic [3:0] b,
                     input logic [31:0] d, output logic [31:0] rd, output logic e);
    req   = 1'b1;
    we    = w;
    addr  = BASE | {20'h0, off};
    be    = b;
    wdata = d;
    check("gnt", {31'h0, gnt}, 32'h1);
    @(negedge clk);
    check("rvalid", {31'h0, rvalid}, 32'h1);
    rd  = rdata;
    e   = err;
    req = 1'b0;
    we  = 1'b0;
  endtask

  task automatic wr(input logic [11:0] off, input logic [31:0] d);
    logic [31:0] rd;
    logic        e;
    bus(1'b1, off, 4'hF, d, rd, e);
    check("wr err", {31'h0, e}, 32'h0);
    check("wr rdata", rd, 32'h0);
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] off, input logic [31:0] exp);
    logic [31:0] rd;
    logic        e;
    bus(1'b0, off, 4'hF, 32'h0, rd, e);
    check({tag, " err"}, {31'h0, e}, 32'h0);
    check(tag, rd, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_regs(input string pfx);
    rd_chk({pfx, " CR"},  CR,  32'h0);
    rd_chk({pfx, " SR"},  SR,  32'h0);
    rd_chk({pfx, " CNT"}, CNT, 32'h0);
    rd_chk({pfx, " CMP"}, CMP, 32'hFFFF_FFFF);
    rd_chk({pfx, " PSC"}, PSC, 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
    repeat (2) @(negedge clk);
    check("rst rvalid", {31'h0, rvalid}, 32'h0);
    check("rst err",    {31'h0, err},    32'h0);
    check("rst rdata",  rdata,           32'h0);
    check("rst irq",    {31'h0, irq},    32'h0);
    rst = 1'b0;
    @(negedge clk);
    check_reset_regs("init");

    // PSC=0, CMP=5, auto-clear with irq: CNT 0..5 then 0
    wr(CMP, 32'd5);
    wr(CR, 32'h7);
    for (int i = 0; i < 6; i++) begin
      rd_chk("cmp5 CNT", CNT, 32'(i));
      if (i == 5) check("irq lag", {31'h0, irq}, 32'h0);
    end
    rd_chk("cmp5 CNT wrap", CNT, 32'h0);
    check("irq set", {31'h0, irq}, 32'h1);
    rd_chk("cmp5 SR", SR, 32'h1);
    rd_chk("CR read", CR, 32'h7);
    wr(CR, 32'h0);
    wr(SR, 32'h1);
    rd_chk("SR cleared", SR, 32'h0);
    check("irq clear", {31'h0, irq}, 32'h0);

    // PSC=3: CNT advances every 4 cycles; CR=0 freezes it
    wr(CMP, 32'hFFFF_FFFF);
    wr(PSC, 32'd3);
    wr(CNT, 32'h0);
    wr(CR, 32'h1);
    for (int i = 0; i < 9; i++) rd_chk("psc3 CNT", CNT, 32'(i / 4));
    wr(CR, 32'h0);
    rd_chk("frozen CNT", CNT, 32'd2);
    rd_chk("frozen CNT", CNT, 32'd2);
    rd_chk("PSC read", PSC, 32'd3);

    // Wrap from 0xFFFF_FFFF without a match
    wr(PSC, 32'h0);
    wr(CMP, 32'h10);
    wr(CNT, 32'hFFFF_FFFF);
    wr(CR, 32'h1);
    rd_chk("wrap CNT before", CNT, 32'hFFFF_FFFF);
    rd_chk("wrap CNT after", CNT, 32'h0);
    rd_chk("wrap SR", SR, 32'h0);

    // W1C in the same cycle as a match tick: match wins
    wr(CR, 32'h0);
    wr(CMP, 32'd2);
    wr(CNT, 32'h0);
    wr(CR, 32'h1);
    rd_chk("race CNT0", CNT, 32'd0);
    rd_chk("race CNT1", CNT, 32'd1);
    wr(SR, 32'h1);
    rd_chk("race SR", SR, 32'h1);
    wr(SR, 32'h1);
    rd_chk("w1c SR", SR, 32'h0);
    wr(CR, 32'h0);

    // Unmapped offsets, be=0 no-op, partial byte write
    bus(1'b0, 12'h020, 4'hF, 32'h0, rd, e);
    check("unmapped rd err", {31'h0, e}, 32'h1);
    check("unmapped rd data", rd, 32'h0);
    bus(1'b1, 12'h024, 4'hF, 32'hFFFF_FFFF, rd, e);
    check("unmapped wr err", {31'h0, e}, 32'h1);
    rd_chk("unmapped CR", CR, 32'h0);
    rd_chk("unmapped CMP", CMP, 32'd2);
    bus(1'b1, CMP, 4'h0, 32'h1234_5678, rd, e);
    check("be0 err", {31'h0, e}, 32'h0);
    rd_chk("be0 CMP", CMP, 32'd2);
    do_reset();
    bus(1'b1, CMP, 4'b0010, 32'hAABB_CCDD, rd, e);
    check("be2 err", {31'h0, e}, 32'h0);
    rd_chk("be2 CMP", CMP, 32'hFFFF_CCFF);
    wr(CR, 32'hFFFF_FFFF);
    rd_chk("CR mask", CR, 32'h7);
    wr(CR, 32'h0);
    wr(PSC, 32'hFFFF_FFFF);
    rd_chk("PSC mask", PSC, 32'h0000_FFFF);

    // Reset in the cycle after a request: response discarded
    wr(CNT, 32'h1234);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = BASE | {20'h0, CR}; be = 4'hF; wdata = 32'h7;
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 1'b0;
    we  = 1'b0;
    @(negedge clk);
    check("rst mid rvalid", {31'h0, rvalid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post rst rvalid", {31'h0, rvalid}, 32'h0);
    end
    check_reset_regs("post");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
